// File: rtl/csa_serial_addsub_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract unit.
package csa_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // Number of slice passes for a given operand width.
  function automatic int nibbles(input int w);
    return w / SLICE_W;
  endfunction

  // Nibble counter width (at least one bit).
  function automatic int cnt_w(input int w);
    return (w / SLICE_W > 1) ? $clog2(w / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/csa_serial_addsub_csa4.sv
// 4-bit carry-select adder slice: both carry-in outcomes are formed in
// parallel and c_in picks one. p is the group propagate.
module csa_4_bit (
  output logic [3:0] sum,
  output logic       c_out,
  output logic       p,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  logic [4:0] s0, s1;

  assign s0    = {1'b0, a} + {1'b0, b};
  assign s1    = {1'b0, a} + {1'b0, b} + 5'd1;
  assign sum   = c_in ? s1[3:0] : s0[3:0];
  assign c_out = c_in ? s1[4]   : s0[4];
  assign p     = &(a ^ b);

endmodule

// File: rtl/csa_serial_addsub.sv
// Multi-cycle add/subtract: one nibble per clock through a single csa_4_bit
// slice. Subtraction uses ~b with carry-in 1. Result and flags are written
// on the edge that enters FIN so they are visible together with done.
module csa_serial_addsub
  import csa_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int CW      = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_r;
  logic             a_msb, b_msb;   // sign bits kept aside; operand regs shift out
  logic [WIDTH-1:0] a_r, b_r, work;
  logic [WIDTH-1:0] res_nx;
  logic [3:0]       sl_sum;
  logic             sl_co;
  logic             sl_p_unused;    // slice propagate is not needed here
  logic             last;

  csa_4_bit u_slice (
    .sum   (sl_sum),
    .c_out (sl_co),
    .p     (sl_p_unused),
    .a     (a_r[3:0]),
    .b     (b_r[3:0]),
    .c_in  (carry)
  );

  assign last   = (cnt == CW'(NIBBLES - 1));
  assign res_nx = {sl_sum, work[WIDTH-1:4]};
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, nibble-serial datapath and result/flag latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      result <= '0;
      cb     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          sub_r <= sub;
          carry <= sub;
          cnt   <= '0;
          a_msb <= a[WIDTH-1];
          b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          carry <= sl_co;
          work  <= res_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result <= res_nx;
            cb     <= sub_r ^ sl_co;   // borrow is the inverted carry
            ovf    <= (a_msb == b_msb) && (res_nx[WIDTH-1] != a_msb);
            zero   <= (res_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_addsub.sv
// Bench for csa_serial_addsub: vector table, random ops against an
// arithmetic model, busy-ignore and mid-run reset sequences.
module tb_csa_serial_addsub;

  localparam int W   = 16;
  localparam int LAT = W / 4 + 1;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cb, ovf, zero;
  logic [W-1:0] result;

  csa_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cb(cb), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a, b, res;
    logic         cb, ovf, zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         cb, ovf, zero;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [W-1:0] last_res;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result",  result, e.res);
        chk("cb",      cb,     e.cb);
        chk("ovf",     ovf,    e.ovf);
        chk("zero",    zero,   e.zero);
        chk("latency", cyc - e.cyc, LAT);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic issue(input vec_t v, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; sub = v.sub; a = v.a; b = v.b;
    if (expect_done) begin
      e.res = v.res; e.cb = v.cb; e.ovf = v.ovf; e.zero = v.zero; e.cyc = cyc;
      q.push_back(e);
      last_res = v.res;
    end
    @(posedge clk); #1;
    start = 1'b0; sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_cmp++; n_err++;
    $display("FAIL done_timeout: got no done expected within 20 cycles");
  endtask

  function automatic vec_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t v;
    int   sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? sx - sy : sx + sy;
    v.sub  = s; v.a = x; v.b = y;
    v.res  = s ? x - y : x + y;
    v.cb   = s ? (x < y) : (({1'b0, x} + {1'b0, y}) > 17'h0FFFF);
    v.ovf  = (r > 32767) || (r < -32768);
    v.zero = (v.res == '0);
    return v;
  endfunction

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 16'h0F0F, 16'hF0F1, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_result", result, 0);
    chk("rst_flags",  {cb, ovf, zero}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i], 1'b1);
      wait_done();
    end

    for (int i = 0; i < 8; i++) begin
      v = model(1'($urandom), W'($urandom), W'($urandom));
      issue(v, 1'b1);
      wait_done();
    end

    // Start while busy is ignored; previous result is held during RUN.
    v = '{1'b1, 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0};
    begin
      logic [W-1:0] prev;
      prev = last_res;
      issue(v, 1'b1);
      @(posedge clk); #1;
      start = 1'b1; sub = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
      chk("busy_in_run", busy, 1);
      chk("result_held", result, prev);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
    end

    // Leave nonzero result/cb, then reset mid-run.
    issue('{1'b1, 16'h8000, 16'h8001, 16'hFFFF, 1'b1, 1'b0, 1'b0}, 1'b1);
    wait_done();
    issue('{1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0}, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy",   busy,   0);
    chk("mid_rst_done",   done,   0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_cb",     cb,     0);
    chk("mid_rst_ovf",    ovf,    0);
    chk("mid_rst_zero",   zero,   0);
    repeat (10) @(posedge clk);
    chk("no_pending", q.size(), 0);

    // Unit still works after the reset.
    issue(tbl[0], 1'b1);
    wait_done();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
